otter_lcd_mmio: RTL and testbench

- Memory-mapped LCD peripheral on the OTTER IO bus, addresses >= 0x00010000.
- Accepts CPU stores through IO_WR/IO_ADDR/IO_DATA, queues them, and drives an HD44780-style 8-bit write-only LCD bus with timed E strobes.
- Returns status on IO_IN for CPU loads. The memory block samples IO_IN on the read-enable edge, so IO_IN is a combinational decode of IO_ADDR over registered state.

---
 rtl/otter_lcd_pkg.sv | 41 ++++
 rtl/lcd_cmd_fifo.sv | 58 +++++
 rtl/otter_lcd_mmio.sv | 179 +++++++++++++++++
 tb/tb_otter_lcd_mmio.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/otter_lcd_pkg.sv
// Shared types and constants for the OTTER memory-mapped LCD peripheral.
package otter_lcd_pkg;

  // Register offsets inside the 4-word window
  localparam logic [31:0] OFS_DATA   = 32'h0000_0000;
  localparam logic [31:0] OFS_CMD    = 32'h0000_0004;
  localparam logic [31:0] OFS_STATUS = 32'h0000_0008;
  localparam logic [31:0] OFS_RSVD   = 32'h0000_000C;

  // STATUS write: setting this bit clears the sticky overflow flag
  localparam int STATUS_OVF_CLR_BIT = 2;

  // One queued LCD transfer: register select plus the byte for DB
  typedef struct packed {
    logic       rs;
    logic [7:0] db;
  } lcd_entry_t;

  typedef enum logic [2:0] {
    POWERUP,
    IDLE,
    SETUP,
    PULSE,
    HOLD,
    EXEC
  } lcd_state_t;

  // Commands (clear display / return home) that need the long execution wait
  localparam int NUM_LONG_CMDS = 3;
  localparam logic [7:0] LONG_CMDS [NUM_LONG_CMDS] = '{8'h01, 8'h02, 8'h03};

  function automatic logic is_long_cmd(input lcd_entry_t e);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < NUM_LONG_CMDS; i++) begin
      if (!e.rs && (e.db == LONG_CMDS[i])) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/lcd_cmd_fifo.sv
// Small circular FIFO of pending LCD transfers. The head is visible
// combinationally so the controller can latch it in the cycle it pops.
module lcd_cmd_fifo
  import otter_lcd_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     push,
  input  lcd_entry_t               push_entry,
  input  logic                     pop,
  output lcd_entry_t               head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  lcd_entry_t      mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            push_ok;
  logic            pop_ok;

  // Fullness is judged on the registered count, so a same-cycle pop
  // never makes room for a push that arrives while full.
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Storage write; contents need no reset because count gates every read
  always_ff @(posedge CLK) begin
    if (push_ok) mem[wr_ptr] <= push_entry;
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally (power-of-two depth)
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/otter_lcd_mmio.sv
// OTTER IO-bus LCD peripheral: decodes CPU stores into a transfer queue and
// plays each entry out on an HD44780-style 8-bit bus with timed E strobes.
module otter_lcd_mmio
  import otter_lcd_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h1100_0100,
  parameter int          FIFO_DEPTH  = 8,
  parameter int          T_POWERUP   = 750000,
  parameter int          T_SETUP     = 4,
  parameter int          T_E_HIGH    = 12,
  parameter int          T_HOLD      = 4,
  parameter int          T_EXEC      = 2000,
  parameter int          T_EXEC_LONG = 82000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] IO_ADDR,
  input  logic [31:0] IO_DATA,
  input  logic        IO_WR,
  output logic [31:0] IO_IN,
  output logic        LCD_RS,
  output logic        LCD_RW,
  output logic        LCD_E,
  output logic [7:0]  LCD_DB
);

  localparam int TMAX = (T_POWERUP > T_EXEC_LONG) ? T_POWERUP : T_EXEC_LONG;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int CW   = $clog2(FIFO_DEPTH) + 1;

  localparam logic [31:0] ADDR_DATA   = BASE_ADDR + OFS_DATA;
  localparam logic [31:0] ADDR_CMD    = BASE_ADDR + OFS_CMD;
  localparam logic [31:0] ADDR_STATUS = BASE_ADDR + OFS_STATUS;

  // Address decode: full compare on the word address, byte offset ignored
  logic sel_data;
  logic sel_cmd;
  logic sel_status;
  logic wr_data;
  logic wr_cmd;
  logic wr_status;

  assign sel_data   = (IO_ADDR[31:2] == ADDR_DATA[31:2]);
  assign sel_cmd    = (IO_ADDR[31:2] == ADDR_CMD[31:2]);
  assign sel_status = (IO_ADDR[31:2] == ADDR_STATUS[31:2]);
  assign wr_data    = IO_WR && sel_data;
  assign wr_cmd     = IO_WR && sel_cmd;
  assign wr_status  = IO_WR && sel_status;

  // Upper store-data bits and the byte offset carry no meaning here
  logic unused_bits;
  assign unused_bits = ^{IO_DATA[31:8], IO_ADDR[1:0]};

  // Transfer queue
  logic              push;
  lcd_entry_t        push_entry;
  logic              pop;
  lcd_entry_t        head;
  logic [CW-1:0]     fifo_count;
  logic              fifo_full;
  logic              fifo_empty;

  assign push       = wr_data || wr_cmd;
  assign push_entry = '{rs: wr_data, db: IO_DATA[7:0]};

  lcd_cmd_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .CLK        (CLK),
    .RST        (RST),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (head),
    .count      (fifo_count),
    .full       (fifo_full),
    .empty      (fifo_empty)
  );

  // Controller state
  lcd_state_t    state_reg;
  lcd_state_t    state_next;
  logic [TW-1:0] timer_reg;
  logic [TW-1:0] timer_load;
  logic          timer_zero;
  lcd_entry_t    cur_reg;
  logic          e_reg;
  logic          e_next;
  logic          overflow_reg;
  logic          busy;

  assign timer_zero = (timer_reg == '0);
  assign pop        = (state_reg == IDLE) && !fifo_empty;
  assign busy       = (state_reg != IDLE) || (fifo_count != '0);

  // Sticky overflow: set by a dropped push, cleared by a STATUS write with bit 2
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      overflow_reg <= 1'b0;
    end else if (push && fifo_full) begin
      overflow_reg <= 1'b1;
    end else if (wr_status && IO_DATA[STATUS_OVF_CLR_BIT]) begin
      overflow_reg <= 1'b0;
    end
  end

  // State register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_reg <= POWERUP;
    else     state_reg <= state_next;
  end

  // Next-state: every timed state leaves once its timer has run down to zero
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      POWERUP: if (timer_zero)  state_next = IDLE;
      IDLE:    if (!fifo_empty) state_next = SETUP;
      SETUP:   if (timer_zero)  state_next = PULSE;
      PULSE:   if (timer_zero)  state_next = HOLD;
      HOLD:    if (timer_zero)  state_next = EXEC;
      EXEC:    if (timer_zero)  state_next = IDLE;
      default:                  state_next = POWERUP;
    endcase
  end

  // Outputs of the FSM: E level for the next cycle and the timer reload for the state being entered
  always_comb begin
    e_next     = (state_next == PULSE);
    timer_load = '0;
    case (state_next)
      SETUP:   timer_load = TW'(T_SETUP - 1);
      PULSE:   timer_load = TW'(T_E_HIGH - 1);
      HOLD:    timer_load = TW'(T_HOLD - 1);
      EXEC:    timer_load = is_long_cmd(cur_reg) ? TW'(T_EXEC_LONG - 1) : TW'(T_EXEC - 1);
      default: timer_load = '0;
    endcase
  end

  // Shared down-counter, reloaded on every state change so each state lasts its full count
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      timer_reg <= TW'(T_POWERUP - 1);
    end else if (state_next != state_reg) begin
      timer_reg <= timer_load;
    end else if (!timer_zero) begin
      timer_reg <= timer_reg - TW'(1);
    end
  end

  // Current transfer doubles as the registered RS/DB drivers; held until the next pop
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)      cur_reg <= '0;
    else if (pop) cur_reg <= head;
  end

  // Registered E strobe, high exactly while in PULSE
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) e_reg <= 1'b0;
    else     e_reg <= e_next;
  end

  assign LCD_RS = cur_reg.rs;
  assign LCD_DB = cur_reg.db;
  assign LCD_E  = e_reg;
  assign LCD_RW = 1'b0;

  // Read mux: only STATUS returns data, everything else reads zero
  always_comb begin
    IO_IN = '0;
    if (sel_status) begin
      IO_IN[0]   = busy;
      IO_IN[1]   = fifo_full;
      IO_IN[2]   = overflow_reg;
      IO_IN[8:4] = 5'(fifo_count);
    end
  end

endmodule

// File: tb/tb_otter_lcd_mmio.sv
// Directed bench for otter_lcd_mmio with a scoreboard of expected LCD strobes.
module tb_otter_lcd_mmio;
  import otter_lcd_pkg::*;

  localparam logic [31:0] BASE = 32'h1100_0100;
  localparam int DEPTH   = 4;
  localparam int TPU     = 10;
  localparam int TSU     = 2;
  localparam int TEH     = 3;
  localparam int THD     = 2;
  localparam int TEX     = 5;
  localparam int TEXL    = 20;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [31:0] IO_ADDR = '0;
  logic [31:0] IO_DATA = '0;
  logic        IO_WR = 1'b0;
  logic [31:0] IO_IN;
  logic        LCD_RS;
  logic        LCD_RW;
  logic        LCD_E;
  logic [7:0]  LCD_DB;

  always #5 CLK = ~CLK;

  otter_lcd_mmio #(
    .BASE_ADDR   (BASE),
    .FIFO_DEPTH  (DEPTH),
    .T_POWERUP   (TPU),
    .T_SETUP     (TSU),
    .T_E_HIGH    (TEH),
    .T_HOLD      (THD),
    .T_EXEC      (TEX),
    .T_EXEC_LONG (TEXL)
  ) dut (
    .CLK     (CLK),
    .RST     (RST),
    .IO_ADDR (IO_ADDR),
    .IO_DATA (IO_DATA),
    .IO_WR   (IO_WR),
    .IO_IN   (IO_IN),
    .LCD_RS  (LCD_RS),
    .LCD_RW  (LCD_RW),
    .LCD_E   (LCD_E),
    .LCD_DB  (LCD_DB)
  );

  int checks = 0;
  int passed = 0;
  logic [8:0] sb [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Strobe monitor: each rising E pops the scoreboard, each falling E checks the width
  logic e_prev = 1'b0;
  int   hi_len = 0;
  always @(negedge CLK) begin
    if (RST) begin
      e_prev = 1'b0;
      hi_len = 0;
    end else begin
      if (LCD_E && !e_prev) begin
        if (sb.size() == 0) begin
          check("sb_nonempty_at_strobe", 32'(sb.size() != 0), 32'd1);
        end else begin
          logic [8:0] exp_e;
          exp_e = sb.pop_front();
          check("strobe_entry", {23'd0, LCD_RS, LCD_DB}, {23'd0, exp_e});
          check("lcd_rw", {31'd0, LCD_RW}, 32'd0);
          $display("strobe rs=%0d db=0x%02h", LCD_RS, LCD_DB);
        end
      end
      if (!LCD_E && e_prev) begin
        check("e_high_len", hi_len, TEH);
        hi_len = 0;
      end
      if (LCD_E) hi_len++;
      e_prev = LCD_E;
    end
  end

  task automatic rd(input logic [31:0] a, output logic [31:0] v);
    IO_ADDR = a;
    #1;
    v = IO_IN;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input bit exp_push, input bit exp_rs);
    IO_ADDR = a;
    IO_DATA = d;
    IO_WR   = 1'b1;
    if (exp_push) sb.push_back({exp_rs, d[7:0]});
    @(negedge CLK);
    IO_WR = 1'b0;
  endtask

  task automatic wait_idle(input int max_cycles, input string tag);
    bit done;
    logic [31:0] v;
    done = 1'b0;
    for (int k = 0; k < max_cycles && !done; k++) begin
      rd(BASE + OFS_STATUS, v);
      if (v[0] == 1'b0) done = 1'b1;
      else @(negedge CLK);
    end
    check(tag, {31'd0, done}, 32'd1);
  endtask

  // Records 64 cycles after a store and extracts the strobe timing
  task automatic capture(output int rise, output int len, output int setup,
                         output int tail, output bit stable);
    bit         e [64];
    bit         r [64];
    logic [7:0] d [64];
    bit         b [64];
    logic [31:0] v;
    int fall;
    int clr;
    for (int k = 0; k < 64; k++) begin
      rd(BASE + OFS_STATUS, v);
      e[k] = LCD_E; r[k] = LCD_RS; d[k] = LCD_DB; b[k] = v[0];
      @(negedge CLK);
    end
    rise = -1; len = 0; setup = 0; tail = -1; stable = 1'b0;
    for (int k = 0; k < 64; k++) if (e[k] && rise < 0) rise = k;
    if (rise >= 0) begin
      for (int k = rise; k < 64 && e[k]; k++) len++;
      fall = rise + len;
      for (int j = rise - 1; j >= 0 && !e[j] && r[j] == r[rise] && d[j] == d[rise]; j--) setup++;
      clr = -1;
      for (int k = fall; k < 64; k++) if (!b[k] && clr < 0) clr = k;
      if (clr >= 0) begin
        tail = clr - fall;
        stable = 1'b1;
        for (int k = fall; k < clr; k++) if (r[k] != r[rise] || d[k] != d[rise]) stable = 1'b0;
      end
    end
  endtask

  task automatic xfer_checks(input string tag, input int exp_tail);
    int rise, len, setup, tail;
    bit stable;
    capture(rise, len, setup, tail, stable);
    $display("%s: rise=%0d setup=%0d e_len=%0d hold+exec=%0d stable=%0d", tag, rise, setup, len, tail, stable);
    check({tag, "_latency"}, rise, 1 + TSU);
    check({tag, "_setup"}, setup, TSU);
    check({tag, "_e_len"}, len, TEH);
    check({tag, "_hold_exec"}, tail, THD + exp_tail);
    check({tag, "_bus_held"}, {31'd0, stable}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v;
    bit found;

    // Reset state
    repeat (3) @(negedge CLK);
    rd(BASE + OFS_STATUS, v);
    check("status_in_reset", v, 32'h1);
    check("lcd_in_reset", {21'd0, LCD_E, LCD_RS, LCD_RW, LCD_DB}, 32'd0);
    @(negedge CLK);
    RST = 1'b0;

    // Powerup window
    for (int i = 0; i < TPU; i++) begin
      rd(BASE + OFS_STATUS, v);
      check("powerup_status", v, 32'h1);
      check("powerup_lcd", {21'd0, LCD_E, LCD_RS, LCD_RW, LCD_DB}, 32'd0);
      @(negedge CLK);
    end
    rd(BASE + OFS_STATUS, v);
    check("powerup_done", v, 32'h0);
    $display("powerup complete status=0x%0h", v);

    // Single data write, long command, normal command, byte-offset alias of CMD
    store(BASE + OFS_DATA, 32'h41, 1'b1, 1'b1);
    xfer_checks("data41", TEX);
    rd(BASE + OFS_STATUS, v);
    check("idle_after_data", v, 32'h0);
    store(BASE + OFS_CMD, 32'h01, 1'b1, 1'b0);
    xfer_checks("cmd01", TEXL);
    store(BASE + OFS_CMD, 32'h38, 1'b1, 1'b0);
    xfer_checks("cmd38", TEX);
    store(BASE + OFS_CMD + 32'h2, 32'hFF0C, 1'b1, 1'b0);
    xfer_checks("cmd0c_alias", TEX);

    // Decode: reserved word and out-of-window addresses
    rd(BASE + OFS_RSVD, v);
    check("read_rsvd", v, 32'h0);
    rd(32'h1100_0000, v);
    check("read_outside", v, 32'h0);
    rd(BASE + OFS_DATA, v);
    check("read_data_reg", v, 32'h0);
    store(BASE + OFS_RSVD, 32'h41, 1'b0, 1'b0);
    store(32'h1100_0000, 32'h42, 1'b0, 1'b0);
    store(BASE + 32'h10, 32'h43, 1'b0, 1'b0);
    repeat (3) @(negedge CLK);
    rd(BASE + OFS_STATUS, v);
    check("ignored_stores", v, 32'h0);
    $display("decode checks done status=0x%0h", v);

    // Overflow during powerup
    #2 RST = 1'b1;
    sb.delete();
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    for (int i = 0; i < 6; i++) store(BASE + OFS_DATA, 32'h30 + i, (i < DEPTH), 1'b1);
    rd(BASE + OFS_STATUS, v);
    check("overflow_status", v, 32'h47);
    store(BASE + OFS_STATUS, 32'h4, 1'b0, 1'b0);
    rd(BASE + OFS_STATUS, v);
    check("overflow_cleared", v, 32'h43);
    wait_idle(200, "drain_overflow");
    check("sb_drained", sb.size(), 32'd0);
    rd(BASE + OFS_STATUS, v);
    check("idle_after_drain", v, 32'h0);

    // Reset in the middle of an E pulse
    store(BASE + OFS_DATA, 32'h55, 1'b1, 1'b1);
    store(BASE + OFS_DATA, 32'h56, 1'b1, 1'b1);
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      if (LCD_E) found = 1'b1;
      else @(negedge CLK);
    end
    check("e_seen_before_reset", {31'd0, found}, 32'd1);
    rd(BASE + OFS_STATUS, v);
    check("status_mid_pulse", v, 32'h11);
    #1 RST = 1'b1;
    #1;
    check("lcd_after_async_reset", {21'd0, LCD_E, LCD_RS, LCD_RW, LCD_DB}, 32'd0);
    rd(BASE + OFS_STATUS, v);
    check("status_after_async_reset", v, 32'h1);
    sb.delete();
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    rd(BASE + OFS_STATUS, v);
    check("powerup_after_reset", v, 32'h1);
    wait_idle(40, "idle_after_reset");
    rd(BASE + OFS_STATUS, v);
    check("final_status", v, 32'h0);
    check("sb_final", sb.size(), 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
